// File: rtl/adder_operand_sequencer_if.sv
// Operand/result bus between the sequencer, its producer/consumer and the external 4-bit adder.
interface adder_operand_sequencer_if;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       cin_in;
  logic       acc_mode;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [4:0] add_sum;
  logic [4:0] result;
  logic       result_valid;
  logic       result_ready;
  logic [3:0] carry_count;
  logic       busy;

  modport slave (
    input  din, din_valid, cin_in, acc_mode, add_sum, result_ready,
    output din_ready, add_a, add_b, add_cin, result, result_valid, carry_count, busy
  );

  modport master (
    output din, din_valid, cin_in, acc_mode, add_sum, result_ready,
    input  din_ready, add_a, add_b, add_cin, result, result_valid, carry_count, busy
  );
endinterface

// File: rtl/adder_operand_sequencer.sv
// Collects A/B nibbles, captures the external adder's sum one cycle after B, holds it until consumed.
// No beats are accepted while adding or while a result is held; acc_mode chains the sum into A.
module adder_operand_sequencer (
  input  logic                             clk,
  input  logic                             reset,
  adder_operand_sequencer_if.slave         bus
);
  typedef enum logic [1:0] {GET_A, GET_B, ADD, HOLD} state_t;

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_cin;
  logic [4:0] r_result;
  logic       r_result_valid;
  logic [3:0] r_carry_count;

  logic       w_din_ready;
  logic       w_accept;

  assign w_din_ready = (r_state == GET_A) || (r_state == GET_B);
  assign w_accept    = bus.din_valid && w_din_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= GET_A;
      r_a            <= 4'd0;
      r_b            <= 4'd0;
      r_cin          <= 1'b0;
      r_result       <= 5'd0;
      r_result_valid <= 1'b0;
      r_carry_count  <= 4'd0;
    end else begin
      case (r_state)
        GET_A: begin
          if (w_accept) begin
            r_a     <= bus.din;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (w_accept) begin
            r_b     <= bus.din;
            r_cin   <= bus.cin_in;
            r_state <= ADD;
          end
        end
        ADD: begin
          // Only edge at which the external adder output is trusted.
          r_result       <= bus.add_sum;
          r_result_valid <= 1'b1;
          if (bus.add_sum[4] && (r_carry_count != 4'd15))
            r_carry_count <= r_carry_count + 4'd1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            if (bus.acc_mode) begin
              r_a     <= r_result[3:0];
              r_state <= GET_B;
            end else begin
              r_state <= GET_A;
            end
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

  assign bus.din_ready    = w_din_ready;
  assign bus.busy         = (r_state != GET_A);
  assign bus.add_a        = r_a;
  assign bus.add_b        = r_b;
  assign bus.add_cin      = r_cin;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.carry_count  = r_carry_count;
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer with a behavioural 4-bit adder on the operand bus.
module tb_adder_operand_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  adder_operand_sequencer_if bus ();

  adder_operand_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents A then B; returns at the negedge after the B edge (block is in ADD).
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic c);
    bus.din = a; bus.cin_in = 1'b0; bus.din_valid = 1'b1;
    step();
    bus.din = b; bus.cin_in = c;
    step();
    bus.din_valid = 1'b0; bus.cin_in = 1'b0; bus.din = 4'd0;
  endtask

  task automatic consume();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL rst_din_ready got=%b exp=1", bus.din_ready); end total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end total++;
    if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'd0) begin bad++; $display("FAIL rst_operands got=%h exp=0", {bus.add_a, bus.add_b, bus.add_cin}); end total++;
    if (bus.result !== 5'd0 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL rst_result got=%b/%b exp=00000/0", bus.result, bus.result_valid); end total++;
    if (bus.carry_count !== 4'd0) begin bad++; $display("FAIL rst_carry_count got=%0d exp=0", bus.carry_count); end total++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send(4'd5, 4'd7, 1'b0);
    if (bus.din_ready !== 1'b0 || bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL basic_add_state got rdy=%b busy=%b vld=%b exp 0/1/0", bus.din_ready, bus.busy, bus.result_valid); end total++;
    if (bus.add_a !== 4'd5 || bus.add_b !== 4'd7 || bus.add_cin !== 1'b0) begin bad++; $display("FAIL basic_operands got=%0d/%0d/%b exp=5/7/0", bus.add_a, bus.add_b, bus.add_cin); end total++;
    step();
    if (bus.result !== 5'b01100 || bus.result_valid !== 1'b1) begin bad++; $display("FAIL basic_result got=%b/%b exp=01100/1", bus.result, bus.result_valid); end total++;
    if (bus.carry_count !== 4'd0) begin bad++; $display("FAIL basic_carry_count got=%0d exp=0", bus.carry_count); end total++;
    consume();
    if (bus.result_valid !== 1'b0 || bus.result !== 5'b01100) begin bad++; $display("FAIL basic_consume got=%b/%b exp=01100/0", bus.result, bus.result_valid); end total++;
    if (bus.busy !== 1'b0 || bus.din_ready !== 1'b1) begin bad++; $display("FAIL basic_back_to_get_a got busy=%b rdy=%b exp 0/1", bus.busy, bus.din_ready); end total++;
  endtask

  task automatic test_carry();
    send(4'd15, 4'd1, 1'b1);
    step();
    if (bus.result !== 5'b10001) begin bad++; $display("FAIL carry_result got=%b exp=10001", bus.result); end total++;
    if (bus.carry_count !== 4'd1) begin bad++; $display("FAIL carry_count got=%0d exp=1", bus.carry_count); end total++;
    consume();
  endtask

  task automatic test_backpressure();
    send(4'd2, 4'd3, 1'b0);
    step();
    bus.din = 4'hF; bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.result !== 5'b00101 || bus.result_valid !== 1'b1 || bus.din_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got=%b/%b rdy=%b exp=00101/1 rdy=0", i, bus.result, bus.result_valid, bus.din_ready); end total++;
      if (bus.add_a !== 4'd2 || bus.add_b !== 4'd3) begin bad++; $display("FAIL bp_operands%0d got=%0d/%0d exp=2/3", i, bus.add_a, bus.add_b); end total++;
      step();
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0; bus.din_valid = 1'b0; bus.din = 4'd0;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 5'b00101) begin bad++; $display("FAIL bp_release got vld=%b busy=%b res=%b exp 0/0/00101", bus.result_valid, bus.busy, bus.result); end total++;
    if (bus.add_a !== 4'd2) begin bad++; $display("FAIL bp_beat_ignored got add_a=%0d exp=2", bus.add_a); end total++;
    if (bus.carry_count !== 4'd1) begin bad++; $display("FAIL bp_carry_count got=%0d exp=1", bus.carry_count); end total++;
  endtask

  task automatic test_accumulate();
    send(4'd3, 4'd4, 1'b0);
    step();
    if (bus.result !== 5'b00111) begin bad++; $display("FAIL acc_first got=%b exp=00111", bus.result); end total++;
    bus.acc_mode = 1'b1; bus.result_ready = 1'b1;
    step();
    bus.acc_mode = 1'b0; bus.result_ready = 1'b0;
    if (bus.busy !== 1'b1 || bus.din_ready !== 1'b1 || bus.add_a !== 4'd7) begin bad++; $display("FAIL acc_get_b got busy=%b rdy=%b a=%0d exp 1/1/7", bus.busy, bus.din_ready, bus.add_a); end total++;
    bus.din = 4'd9; bus.cin_in = 1'b0; bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0; bus.din = 4'd0;
    if (bus.add_a !== 4'd7 || bus.add_b !== 4'd9) begin bad++; $display("FAIL acc_operands got=%0d/%0d exp=7/9", bus.add_a, bus.add_b); end total++;
    step();
    if (bus.result !== 5'b10000 || bus.result_valid !== 1'b1) begin bad++; $display("FAIL acc_result got=%b/%b exp=10000/1", bus.result, bus.result_valid); end total++;
    if (bus.carry_count !== 4'd2) begin bad++; $display("FAIL acc_carry_count got=%0d exp=2", bus.carry_count); end total++;
    consume();
  endtask

  task automatic test_reset_midop();
    bus.din = 4'd6; bus.din_valid = 1'b1;
    step();
    bus.din_valid = 1'b0; bus.din = 4'd0;
    if (bus.busy !== 1'b1 || bus.add_a !== 4'd6) begin bad++; $display("FAIL midop_a_loaded got busy=%b a=%0d exp 1/6", bus.busy, bus.add_a); end total++;
    reset = 1'b1;
    #1;
    if (bus.busy !== 1'b0 || bus.din_ready !== 1'b1 || bus.add_a !== 4'd0 || bus.add_b !== 4'd0 || bus.add_cin !== 1'b0) begin bad++; $display("FAIL midop_async_reset got busy=%b rdy=%b a=%0d b=%0d c=%b exp 0/1/0/0/0", bus.busy, bus.din_ready, bus.add_a, bus.add_b, bus.add_cin); end total++;
    if (bus.result !== 5'd0 || bus.result_valid !== 1'b0 || bus.carry_count !== 4'd0) begin bad++; $display("FAIL midop_reset_result got=%b/%b cnt=%0d exp 00000/0/0", bus.result, bus.result_valid, bus.carry_count); end total++;
    @(negedge clk);
    reset = 1'b0;
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL midop_ready_ignored got busy=%b vld=%b exp 0/0", bus.busy, bus.result_valid); end total++;
    send(4'd1, 4'd2, 1'b0);
    if (bus.add_a !== 4'd1 || bus.add_b !== 4'd2) begin bad++; $display("FAIL midop_new_a got=%0d/%0d exp=1/2", bus.add_a, bus.add_b); end total++;
    step();
    if (bus.result !== 5'b00011) begin bad++; $display("FAIL midop_result got=%b exp=00011", bus.result); end total++;
    consume();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int i = 1; i <= 16; i++) begin
      send(4'd15, 4'd15, 1'b1);
      step();
      exp_cnt = (i > 15) ? 15 : i;
      if (bus.result !== 5'b11111) begin bad++; $display("FAIL sat_result%0d got=%b exp=11111", i, bus.result); end total++;
      if (bus.carry_count !== exp_cnt[3:0]) begin bad++; $display("FAIL sat_count%0d got=%0d exp=%0d", i, bus.carry_count, exp_cnt); end total++;
      consume();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.din = 4'd0; bus.din_valid = 1'b0; bus.cin_in = 1'b0;
    bus.acc_mode = 1'b0; bus.result_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_accumulate();
    test_reset_midop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
